// File: rtl/interconn_pkg.sv
// Shared definitions for the MVU-to-MVU crossbar: default MVU count, pointer
// width helper, destination mask type and modular index arithmetic.
package interconn_pkg;

    localparam int N_MVU = 8;

    typedef logic [N_MVU-1:0] dst_mask_t;

    function automatic int ptr_w(input int n);
        return $clog2(n);
    endfunction

    // (base + ofs) mod n, valid while both operands are below n
    function automatic int wrap_add(input int base, input int ofs, input int n);
        int sum;
        sum = base + ofs;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/interconn_rr_sched_if.sv
// Request/grant bundle between the MVU senders (master) and the round-robin
// crossbar scheduler (slave).
interface interconn_rr_sched_if
    import interconn_pkg::*;
#(
    parameter int N    = N_MVU,
    parameter int PTRW = ptr_w(N)
) ();

    logic [N-1:0]    req;
    logic [N-1:0]    req_to [N];
    logic [N-1:0]    req_lock;
    logic [N-1:0]    gnt;
    logic [N-1:0]    gnt_to [N];
    logic [N-1:0]    dst_busy;
    logic [PTRW-1:0] rr_ptr;

    modport master (
        output req, req_to, req_lock,
        input  gnt, gnt_to, dst_busy, rr_ptr
    );

    modport slave (
        input  req, req_to, req_lock,
        output gnt, gnt_to, dst_busy, rr_ptr
    );

endinterface

// File: rtl/interconn_rr_scan.sv
// Combinational round-robin scan: walks eligible sources from rr_ptr onward and
// grants each one whose whole destination mask is still unclaimed.
module interconn_rr_scan
    import interconn_pkg::*;
#(
    parameter int N    = N_MVU,
    parameter int PTRW = ptr_w(N)
) (
    input  logic [N-1:0]    elig_rot_i,
    input  logic [N-1:0]    mask_i [N],
    input  logic [N-1:0]    seed_i,
    input  logic [PTRW-1:0] rr_ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [PTRW-1:0] first_o,
    output logic            any_o
);

    logic [N-1:0]    claimed;
    logic [PTRW-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        claimed = seed_i;
        gnt_o   = '0;
        first_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTRW'(wrap_add(int'(rr_ptr_i), k, N));
            // All-or-nothing: a multicast either gets every destination or none
            if (elig_rot_i[k] && ((mask_i[idx] & claimed) == '0)) begin
                gnt_o[idx] = 1'b1;
                claimed    = claimed | mask_i[idx];
                if (!any_o) begin
                    first_o = idx;
                    any_o   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/interconn_rr_sched.sv
// Round-robin crossbar grant scheduler: registered, conflict-free grants with
// locked multi-beat bursts that keep their latched destinations.
module interconn_rr_sched
    import interconn_pkg::*;
#(
    parameter int N    = N_MVU,
    parameter int PTRW = ptr_w(N)
) (
    input  logic                 clk,
    input  logic                 clr_n,
    interconn_rr_sched_if.slave  bus
);

    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    gnt_to_q [N];
    logic [N-1:0]    gnt_to_d [N];
    logic [N-1:0]    dst_busy_q, dst_busy_d;
    logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]    owner;
    logic [N-1:0]    elig;
    logic [N-1:0]    elig_rot;
    logic [N-1:0]    seed;
    logic [N-1:0]    new_gnt;
    logic [PTRW-1:0] first_idx;
    logic            any_new;

    // Owners keep their latched mask; everyone else competes in the scan.
    // A source whose grant just ended without lock sits out one cycle.
    always_comb begin
        owner    = '0;
        elig     = '0;
        elig_rot = '0;
        seed     = '0;
        for (int i = 0; i < N; i++) begin
            owner[i] = gnt_q[i] & bus.req_lock[i] & bus.req[i];
            elig[i]  = bus.req[i] & (|bus.req_to[i])
                     & ~(gnt_q[i] & ~bus.req_lock[i]) & ~owner[i];
            if (owner[i]) begin
                seed = seed | gnt_to_q[i];
            end
        end
        for (int k = 0; k < N; k++) begin
            elig_rot[k] = elig[PTRW'(wrap_add(int'(rr_ptr_q), k, N))];
        end
    end

    interconn_rr_scan #(
        .N    (N),
        .PTRW (PTRW)
    ) u_scan (
        .elig_rot_i (elig_rot),
        .mask_i     (bus.req_to),
        .seed_i     (seed),
        .rr_ptr_i   (rr_ptr_q),
        .gnt_o      (new_gnt),
        .first_o    (first_idx),
        .any_o      (any_new)
    );

    always_comb begin
        gnt_d      = '0;
        dst_busy_d = '0;
        rr_ptr_d   = rr_ptr_q;
        for (int i = 0; i < N; i++) begin
            gnt_to_d[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (owner[i]) begin
                gnt_d[i]    = 1'b1;
                gnt_to_d[i] = gnt_to_q[i];
            end else if (new_gnt[i]) begin
                gnt_d[i]    = 1'b1;
                gnt_to_d[i] = bus.req_to[i];
            end
            dst_busy_d = dst_busy_d | gnt_to_d[i];
        end
        // Only freshly granted sources advance priority; owners never do
        if (any_new) begin
            rr_ptr_d = PTRW'(wrap_add(int'(first_idx), 1, N));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            gnt_q      <= '0;
            dst_busy_q <= '0;
            rr_ptr_q   <= '0;
            for (int i = 0; i < N; i++) begin
                gnt_to_q[i] <= '0;
            end
        end else begin
            gnt_q      <= gnt_d;
            dst_busy_q <= dst_busy_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int i = 0; i < N; i++) begin
                gnt_to_q[i] <= gnt_to_d[i];
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.gnt_to   = gnt_to_q;
    assign bus.dst_busy = dst_busy_q;
    assign bus.rr_ptr   = rr_ptr_q;

endmodule

// File: tb/tb_interconn_rr_sched.sv
// Scoreboard bench for interconn_rr_sched at N=4: directed steps push expected
// grant state; a monitor pops and compares one edge later.
module tb_interconn_rr_sched;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic clr_n = 1'b1;

    always #5 clk = ~clk;

    interconn_rr_sched_if #(.N(N)) bus ();

    interconn_rr_sched #(.N(N)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  gnt;
        logic [15:0] gnt_to;
        logic [1:0]  ptr;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] dut_gnt_to();
        logic [15:0] f;
        for (int i = 0; i < N; i++) f[i*4 +: 4] = bus.gnt_to[i];
        return f;
    endfunction

    function automatic logic [3:0] busy_of(input logic [15:0] m);
        return m[3:0] | m[7:4] | m[11:8] | m[15:12];
    endfunction

    // Drive one cycle of requests; expected state applies after the next edge
    task automatic step(input string name, input logic [3:0] req, input logic [3:0] lock,
                        input logic [15:0] to, input logic [3:0] eg,
                        input logic [15:0] eto, input logic [1:0] ep);
        exp_t e;
        @(negedge clk);
        bus.req      = req;
        bus.req_lock = lock;
        for (int i = 0; i < N; i++) bus.req_to[i] = to[i*4 +: 4];
        e.name   = name;
        e.gnt    = eg;
        e.gnt_to = eto;
        e.ptr    = ep;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".gnt"},      32'(bus.gnt),      32'(e.gnt));
                check({e.name, ".gnt_to"},   32'(dut_gnt_to()), 32'(e.gnt_to));
                check({e.name, ".dst_busy"}, 32'(bus.dst_busy), 32'(busy_of(e.gnt_to)));
                check({e.name, ".rr_ptr"},   32'(bus.rr_ptr),   32'(e.ptr));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_zero(input string name);
        check({name, ".gnt"},      32'(bus.gnt),      32'h0);
        check({name, ".gnt_to"},   32'(dut_gnt_to()), 32'h0);
        check({name, ".dst_busy"}, 32'(bus.dst_busy), 32'h0);
        check({name, ".rr_ptr"},   32'(bus.rr_ptr),   32'h0);
    endtask

    initial begin : stimulus
        bus.req      = '0;
        bus.req_lock = '0;
        for (int i = 0; i < N; i++) bus.req_to[i] = '0;
        #1 clr_n = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        // Conflict on one destination, pointer starts at 0
        step("conf_c1",   4'b0011, 4'b0000, 16'h0044, 4'b0001, 16'h0004, 2'd1);
        step("conf_c2",   4'b0011, 4'b0000, 16'h0044, 4'b0010, 16'h0040, 2'd2);
        step("conf_c3",   4'b0011, 4'b0000, 16'h0044, 4'b0001, 16'h0004, 2'd1);
        step("conf_idle", 4'b0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 2'd1);

        // Disjoint masks granted in parallel
        step("par",       4'b0101, 4'b0000, 16'h0601, 4'b0101, 16'h0601, 2'd3);
        step("par_idle",  4'b0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 2'd3);

        // 3-beat burst from src3 with pointer wrap; src1 follows with no gap
        step("burst_b1",   4'b1010, 4'b1000, 16'h8080, 4'b1000, 16'h8000, 2'd0);
        step("burst_b2",   4'b1010, 4'b1000, 16'h8080, 4'b1000, 16'h8000, 2'd0);
        step("burst_b3",   4'b1010, 4'b1000, 16'h4080, 4'b1000, 16'h8000, 2'd0);
        step("burst_next", 4'b1010, 4'b0000, 16'h4080, 4'b0010, 16'h0080, 2'd2);
        step("burst_idle", 4'b0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 2'd2);

        // Multicast waits for src1's burst to release
        step("mc_own",  4'b0010, 4'b0010, 16'h0020, 4'b0010, 16'h0020, 2'd2);
        step("mc_part", 4'b0111, 4'b0010, 16'h0123, 4'b0110, 16'h0120, 2'd3);
        step("mc_wait", 4'b0011, 4'b0010, 16'h0023, 4'b0010, 16'h0020, 2'd3);
        step("mc_rel",  4'b0011, 4'b0000, 16'h0023, 4'b0001, 16'h0003, 2'd1);
        step("mc_idle", 4'b0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 2'd1);

        // Zero destination mask is never granted and never moves the pointer
        step("zero_to",  4'b1000, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 2'd1);
        step("zero_mix", 4'b1100, 4'b0000, 16'h0400, 4'b0100, 16'h0400, 2'd3);
        step("zero_ptr", 4'b1000, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 2'd3);

        // Asynchronous reset in the middle of a locked burst
        step("rst_b1", 4'b0001, 4'b0001, 16'h0001, 4'b0001, 16'h0001, 2'd1);
        step("rst_b2", 4'b0001, 4'b0001, 16'h0001, 4'b0001, 16'h0001, 2'd1);
        @(posedge clk);
        #3 clr_n = 1'b0;
        #1 check_zero("rst_async");
        @(negedge clk);
        bus.req      = '0;
        bus.req_lock = '0;
        @(negedge clk);
        clr_n = 1'b1;
        step("post_rst_idle1", 4'b0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 2'd0);
        step("post_rst_idle2", 4'b0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 2'd0);
        step("post_rst_gnt",   4'b0001, 4'b0000, 16'h0001, 4'b0001, 16'h0001, 2'd1);
        step("final_idle",     4'b0000, 4'b0000, 16'h0000, 4'b0000, 16'h0000, 2'd1);

        for (int w = 0; w < 5; w++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        check("drain", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interconn_rr_sched.md
# interconn_rr_sched

Round-robin grant scheduler that shares the MVU-to-MVU crossbar between the N MVU senders. Each MVU posts a send request with a destination mask. Every cycle the scheduler issues a registered, conflict-free set of grants, so that no two granted senders target the same destination in the same cycle. Grants are all-or-nothing for multicast, support locked multi-beat bursts, and are starvation-free. A sender drives the crossbar's `send_en`, `send_to`, `send_addr` and `send_word` only in a cycle where its grant is high.

## Interface
Parameters:
- `N`, default 8: number of MVUs (sources = destinations); N ≥ 2.
- `PTRW`, default `$clog2(N)`: width of the round-robin pointer.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `clr_n` input, 1 bit: reset, asynchronous, active-low.
- `req` input, [N-1:0]: `req[i]` means source i requests a grant.
- `req_to` input, [N-1:0] per source, unpacked [N-1:0]: destination mask of source i; the self bit is allowed.
- `req_lock` input, [N-1:0]: sampled only in cycles where `gnt[i]`=1; 1 keeps the grant for the next beat.
- `gnt` output, [N-1:0], registered: `gnt[i]`=1 means source i owns destinations `gnt_to[i]` in this cycle.
- `gnt_to` output, [N-1:0] per source, unpacked [N-1:0], registered: latched destination mask of each granted source; 0 when not granted.
- `dst_busy` output, [N-1:0], registered: OR of all `gnt_to` masks.
- `rr_ptr` output, [PTRW-1:0], registered: current highest-priority source, for debug and coverage.

## Operation
- Eligibility at each edge. Source i is eligible if all of the following hold:
  - `req[i]`=1
  - `req_to[i]`≠0
  - not (`gnt[i]`=1 and `req_lock[i]`=0). A just-finished single beat or final burst beat never re-grants back-to-back.
- Owners. Source i with `gnt[i]`=1, `req_lock[i]`=1 and `req[i]`=1 is an owner.
  - It is granted again unconditionally with its latched `gnt_to[i]`.
  - `req_to` changes while owning are ignored.
  - Owners' masks are claimed before any scan.
- Scan. Non-owner eligible sources are visited in order `rr_ptr`, `rr_ptr`+1, …, wrapping mod N.
  - Source i is granted iff `req_to[i]` & claimed == 0; claimed then |= `req_to[i]`.
  - Partial multicast grants never happen.
- Pointer update.
  - If at least one non-owner was granted: `rr_ptr` ← (first non-owner granted in scan order + 1) mod N.
  - Otherwise `rr_ptr` holds.
  - Owners never move the pointer.
- Release. An owner dropping `req` (abort) or `req_lock` (last beat) frees its destinations at the next edge. The freed destinations are available to other sources in that same arbitration.
- `req_to`=0 with `req`=1 is never granted and has no other effect.
- Burst of L beats: hold `req`; `req_lock`=1 on beats 1..L-1, `req_lock`=0 on beat L.

## Timing
- Reset values: `gnt`=0, `gnt_to`=0 for every source, `dst_busy`=0, `rr_ptr`=0, owner state cleared.
- Reset is asynchronous and takes effect immediately, including mid-burst. The first grant is possible in the cycle after the first rising edge with `clr_n`=1.
- Latency: `req` sampled at edge k produces `gnt` during cycle k+1. The source sends during that cycle and updates `req` at edge k+1.
- Single-beat throughput: one grant per source every 2 cycles.
- Locked-burst throughput: 1 beat per cycle.
- Worst-case wait for an eligible non-locked source: N−1 competing grants plus the bursts in progress.
- Simultaneous events, all resolved in the same edge:
  - owner releases while another source requests the same destination → that source can be granted on the next cycle with no gap;
  - `rr_ptr` wrap from N−1 to 0.

## Structure
- Shared package `interconn_pkg`: N default, `PTRW` helper, and the `dst_mask_t` typedef ([N-1:0]). The crossbar and MVU send logic share it.
- Sub-module `interconn_rr_scan`: purely combinational. Takes rotated eligibility, masks, the claimed seed and `rr_ptr`; returns the new-grant vector and the first-granted index.
- Top level holds all registers: `gnt`, `gnt_to`, `dst_busy`, `rr_ptr`.
- Expected size: about 150–250 lines of RTL.

## Test plan
All scenarios use N=4.
- Reset: assert `clr_n`=0 mid-traffic → `gnt`, `gnt_to`, `dst_busy` and `rr_ptr` go to 0 immediately; after release with no `req`, they stay 0.
- Conflict, with `rr_ptr`=0: src0 and src1 both request `req_to`=4'b0100 and hold `req` → `gnt`=0001 in cycle 1, then 0010 in cycle 2, and `rr_ptr`=2 after that.
- Parallel grants: src0 to 0001 and src2 to 0110 → `gnt`=0101 and `dst_busy`=0111 in the same cycle.
- Burst: src3 sends 3 beats to 1000 with `req_lock` 1,1,0 while src1 requests 1000 → `gnt[3]`=1 for 3 consecutive cycles, then `gnt[1]`=1 in the very next cycle.
- Multicast all-or-nothing: src1 owns 0010 in a burst; src0 requests 0011; src2 requests 0001 →
  - src2 is granted;
  - src0 has `gnt`=0 until src1 releases, then gets `gnt_to`=0011.
- Edge cases:
  - `req_to`=0 with `req`=1 → never granted;
  - changing `req_to` of an owner mid-burst → `gnt_to` unchanged.
